// File: rtl/mat_vec_engine_pkg.sv
// Shared encodings for mat_vec_engine: vector-type codes, FSM states and
// the vector-element to matrix-coordinate mapping.
package mat_vec_engine_pkg;

    localparam logic [1:0] VtCol      = 2'b00;
    localparam logic [1:0] VtRow      = 2'b01;
    localparam logic [1:0] VtDiag     = 2'b10;
    localparam logic [1:0] VtAntiDiag = 2'b11;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMac   = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    // Row of element i of vector idx; dim is a power of two.
    function automatic int unsigned vec_row(input logic [1:0] vtype, input int unsigned idx,
                                            input int unsigned i, input int unsigned dim);
        int unsigned r;
        case (vtype)
            VtCol:   r = i;
            VtRow:   r = idx;
            VtDiag:  r = i;
            default: r = (2 * dim - 1 - i - idx) % dim;
        endcase
        return r;
    endfunction

    // Column of element i of vector idx.
    function automatic int unsigned vec_col(input logic [1:0] vtype, input int unsigned idx,
                                            input int unsigned i, input int unsigned dim);
        int unsigned c;
        case (vtype)
            VtCol:   c = idx;
            VtRow:   c = i;
            VtDiag:  c = (i + idx) % dim;
            default: c = i;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mat_vec_engine_dot.sv
// mve_dot: combinational signed fixed-point dot product with round-half-up.
// Define MAT_VEC_ENGINE_SATURATE_EN to saturate the result instead of wrapping.
module mve_dot #(
    parameter int unsigned DIM   = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 12
) (
    input  logic [DIM*WIDTH-1:0] row,
    input  logic [DIM*WIDTH-1:0] vec,
    output logic [WIDTH-1:0]     result
);

    localparam int unsigned CW = $clog2(DIM);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + CW;

    localparam logic signed [AW-1:0] Half   = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] SatMax = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [WIDTH-1:0] a, b;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    acc, rounded, shifted;

    always_comb begin
        acc  = '0;
        a    = '0;
        b    = '0;
        prod = '0;
        for (int i = 0; i < DIM; i++) begin
            a    = row[i*WIDTH +: WIDTH];
            b    = vec[i*WIDTH +: WIDTH];
            prod = PW'(a) * PW'(b);
            acc  = acc + AW'(prod);
        end
        rounded = acc + Half;
        shifted = rounded >>> FRAC;
`ifdef MAT_VEC_ENGINE_SATURATE_EN
        if (shifted > SatMax) begin
            result = SatMax[WIDTH-1:0];
        end else if (shifted < SatMin) begin
            result = SatMin[WIDTH-1:0];
        end else begin
            result = WIDTH'(shifted);
        end
`else
        result = WIDTH'(shifted);
`endif
    end

endmodule

// File: rtl/mat_vec_engine.sv
// Matrix store with column/row/diag/antidiag vector access and a sequential
// matrix x column engine. Optional macro: MAT_VEC_ENGINE_SATURATE_EN.
module mat_vec_engine
    import mat_vec_engine_pkg::*;
#(
    parameter int unsigned DIM       = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC      = 12,
    parameter int unsigned MAT_COUNT = 4,
    localparam int unsigned IW       = $clog2(MAT_COUNT),
    localparam int unsigned CW       = $clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dat_cyc,
    input  logic                 dat_we,
    input  logic [IW-1:0]        dat_mat_idx,
    input  logic [1:0]           dat_vector_type,
    input  logic [CW-1:0]        dat_vector_idx,
    input  logic [DIM*WIDTH-1:0] dat_in,
    output logic [DIM*WIDTH-1:0] dat_out,
    output logic                 dat_ack,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IW-1:0]        cmd_mul_idx,
    input  logic [IW-1:0]        cmd_src_idx,
    input  logic [IW-1:0]        cmd_dst_idx,
    input  logic [CW-1:0]        cmd_src_col,
    input  logic [CW-1:0]        cmd_dst_col,
    output logic                 busy,
    output logic                 done
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mat_q  [MAT_COUNT][DIM][DIM];
    logic [WIDTH-1:0] snap_q [DIM];
    logic [WIDTH-1:0] res_q  [DIM];
    logic [IW-1:0]    mul_q, dst_q;
    logic [CW-1:0]    dst_col_q, row_q;

    logic [CW-1:0]        vec_r [DIM];
    logic [CW-1:0]        vec_c [DIM];
    logic                 idle, dat_wr, cmd_go;
    logic [DIM*WIDTH-1:0] mul_row, snap_vec;
    logic [WIDTH-1:0]     dot_res;

    assign idle      = (state_q == StIdle);
    assign dat_ack   = rst_n & dat_cyc & idle;
    assign cmd_ready = rst_n & idle & ~dat_cyc;
    assign busy      = ~idle;
    assign done      = (state_q == StWrite);
    assign dat_wr    = dat_ack & dat_we;
    assign cmd_go    = cmd_valid & cmd_ready;

    always_comb begin
        dat_out = '0;
        for (int i = 0; i < DIM; i++) begin
            vec_r[i] = CW'(vec_row(dat_vector_type, 32'(dat_vector_idx), i, DIM));
            vec_c[i] = CW'(vec_col(dat_vector_type, 32'(dat_vector_idx), i, DIM));
            dat_out[i*WIDTH +: WIDTH] = mat_q[dat_mat_idx][vec_r[i]][vec_c[i]];
        end
    end

    always_comb begin
        mul_row  = '0;
        snap_vec = '0;
        for (int c = 0; c < DIM; c++) begin
            mul_row[c*WIDTH +: WIDTH]  = mat_q[mul_q][row_q][c];
            snap_vec[c*WIDTH +: WIDTH] = snap_q[c];
        end
    end

    mve_dot #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_dot (
        .row    (mul_row),
        .vec    (snap_vec),
        .result (dot_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cmd_go) state_d = StMac;
            StMac:   if (row_q == CW'(DIM - 1)) state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mul_q     <= '0;
            dst_q     <= '0;
            dst_col_q <= '0;
            row_q     <= '0;
            for (int r = 0; r < DIM; r++) begin
                snap_q[r] <= '0;
                res_q[r]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (cmd_go) begin
                mul_q     <= cmd_mul_idx;
                dst_q     <= cmd_dst_idx;
                dst_col_q <= cmd_dst_col;
                row_q     <= '0;
                // Snapshot makes src/dst aliasing safe: the product sees pre-command data.
                for (int r = 0; r < DIM; r++) begin
                    snap_q[r] <= mat_q[cmd_src_idx][r][cmd_src_col];
                end
            end
            if (state_q == StMac) begin
                res_q[row_q] <= dot_res;
                row_q        <= row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < MAT_COUNT; m++) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        mat_q[m][r][c] <= '0;
                    end
                end
            end
        end else if (dat_wr) begin
            for (int i = 0; i < DIM; i++) begin
                mat_q[dat_mat_idx][vec_r[i]][vec_c[i]] <= dat_in[i*WIDTH +: WIDTH];
            end
        end else if (state_q == StWrite) begin
            for (int r = 0; r < DIM; r++) begin
                mat_q[dst_q][r][dst_col_q] <= res_q[r];
            end
        end
    end

endmodule

// File: tb/tb_mat_vec_engine.sv
// Self-checking bench for mat_vec_engine: addressing table, scoreboarded
// commands and hand-written handshake / reset sequences.
module tb_mat_vec_engine;
    import mat_vec_engine_pkg::*;

    localparam int unsigned DIM = 4, WIDTH = 16, FRAC = 12, MAT_COUNT = 4;
    localparam int unsigned IW = 2, CW = 2, VW = DIM * WIDTH;

    logic          clk, rst_n;
    logic          dat_cyc, dat_we;
    logic [IW-1:0] dat_mat_idx;
    logic [1:0]    dat_vector_type;
    logic [CW-1:0] dat_vector_idx;
    logic [VW-1:0] dat_in, dat_out;
    logic          dat_ack, cmd_valid, cmd_ready, busy, done;
    logic [IW-1:0] cmd_mul_idx, cmd_src_idx, cmd_dst_idx;
    logic [CW-1:0] cmd_src_col, cmd_dst_col;

    mat_vec_engine #(
        .DIM       (DIM),
        .WIDTH     (WIDTH),
        .FRAC      (FRAC),
        .MAT_COUNT (MAT_COUNT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dat_cyc         (dat_cyc),
        .dat_we          (dat_we),
        .dat_mat_idx     (dat_mat_idx),
        .dat_vector_type (dat_vector_type),
        .dat_vector_idx  (dat_vector_idx),
        .dat_in          (dat_in),
        .dat_out         (dat_out),
        .dat_ack         (dat_ack),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mul_idx     (cmd_mul_idx),
        .cmd_src_idx     (cmd_src_idx),
        .cmd_dst_idx     (cmd_dst_idx),
        .cmd_src_col     (cmd_src_col),
        .cmd_dst_col     (cmd_dst_col),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    wm, wt, wi;
        logic [VW-1:0] wd;
        logic [1:0]    rm, rt, ri;
        logic [VW-1:0] exp;
    } vec_t;

    typedef struct packed {
        logic [1:0]    mat;
        logic [1:0]    col;
        logic [VW-1:0] vec;
    } sb_t;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   sh [4][4][4];
    sb_t           sbq [$];
    vec_t          tab [6];
    logic [VW-1:0] v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int m = 0; m < 4; m++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) sh[m][r][c] = '0;
        sbq.delete();
    endtask

    function automatic void vmap(input logic [1:0] vt, input int idx, input int i,
                                 output int r, output int c);
        case (vt)
            2'b00:   begin r = i;   c = idx; end
            2'b01:   begin r = idx; c = i;   end
            2'b10:   begin r = i;   c = (i + idx) % 4; end
            default: begin r = ((3 - i - idx) % 4 + 4) % 4; c = i; end
        endcase
    endfunction

    function automatic logic [15:0] mdot(input int m, input int r, input logic [63:0] snap);
        longint s;
        s = 0;
        for (int c = 0; c < 4; c++)
            s += longint'($signed(sh[m][r][c])) * longint'($signed(snap[c*16 +: 16]));
        s = s + 2048;
        s = s >>> 12;
`ifdef MAT_VEC_ENGINE_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        dat_cyc   = 1'b0;
        dat_we    = 1'b0;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic do_write(input int m, input logic [1:0] vt, input int idx,
                            input logic [63:0] d);
        int r, c;
        @(negedge clk);
        dat_cyc = 1'b1; dat_we = 1'b1; dat_mat_idx = IW'(m);
        dat_vector_type = vt; dat_vector_idx = CW'(idx); dat_in = d;
        #1 check("wr_ack", 64'(dat_ack), 64'd1);
        for (int i = 0; i < 4; i++) begin
            vmap(vt, idx, i, r, c);
            sh[m][r][c] = d[i*16 +: 16];
        end
        @(negedge clk);
        dat_cyc = 1'b0; dat_we = 1'b0;
    endtask

    task automatic do_read(input int m, input logic [1:0] vt, input int idx,
                           output logic [63:0] rv);
        dat_mat_idx = IW'(m); dat_vector_type = vt; dat_vector_idx = CW'(idx);
        #1 rv = dat_out;
    endtask

    // Drives a command and pushes its model result; returns with cmd_valid high.
    task automatic start_cmd(input int mul, input int src, input int scol, input int dst,
                             input int dcol);
        logic [63:0] snap, res;
        sb_t e;
        for (int r = 0; r < 4; r++) snap[r*16 +: 16] = sh[src][r][scol];
        for (int r = 0; r < 4; r++) res[r*16 +: 16] = mdot(mul, r, snap);
        for (int r = 0; r < 4; r++) sh[dst][r][dcol] = res[r*16 +: 16];
        e.mat = 2'(dst); e.col = 2'(dcol); e.vec = res;
        sbq.push_back(e);
        cmd_mul_idx = IW'(mul); cmd_src_idx = IW'(src); cmd_src_col = CW'(scol);
        cmd_dst_idx = IW'(dst); cmd_dst_col = CW'(dcol);
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        #1 check("cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 check("busy_mac", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int start);
        int cnt;
        sb_t e;
        logic [63:0] rv;
        cnt = start;
        while (done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            #1 cnt++;
        end
        check("done_latency", 64'(cnt), 64'(DIM + 1));
        @(negedge clk);
        #1 check("idle_after", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd0);
        if (sbq.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            do_read(int'(e.mat), VtCol, int'(e.col), rv);
            check("sb_result", rv, e.vec);
        end
    endtask

    task automatic run_cmd(input int mul, input int src, input int scol, input int dst,
                           input int dcol);
        @(negedge clk);
        start_cmd(mul, src, scol, dst, dcol);
        wait_accept();
        wait_done(1);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; dat_cyc = 1'b1; dat_we = 1'b1; cmd_valid = 1'b1;
        dat_mat_idx = '0; dat_vector_type = '0; dat_vector_idx = '0; dat_in = '0;
        cmd_mul_idx = '0; cmd_src_idx = '0; cmd_dst_idx = '0;
        cmd_src_col = '0; cmd_dst_col = '0;
        clear_model();
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ack", 64'(dat_ack), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        dat_cyc = 1'b0; dat_we = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(0, VtRow, 0, v);
        check("rst_mat", v, 64'd0);

        // Addressing table: write one vector after reset, read through another view.
        tab[0] = '{2'd0, VtAntiDiag, 2'd0, 64'h0004_0003_0002_0001,
                   2'd0, VtRow, 2'd0, 64'h0004_0000_0000_0000};
        tab[1] = '{2'd1, VtCol, 2'd1, 64'h0004_0003_0002_0001,
                   2'd1, VtRow, 2'd2, 64'h0000_0000_0003_0000};
        tab[2] = '{2'd2, VtDiag, 2'd1, 64'h0004_0003_0002_0001,
                   2'd2, VtCol, 2'd0, 64'h0004_0000_0000_0000};
        tab[3] = '{2'd0, VtRow, 2'd3, 64'h0008_0007_0006_0005,
                   2'd0, VtAntiDiag, 2'd1, 64'h0008_0000_0000_0000};
        tab[4] = '{2'd3, VtDiag, 2'd0, 64'h0004_0003_0002_0001,
                   2'd3, VtDiag, 2'd0, 64'h0004_0003_0002_0001};
        tab[5] = '{2'd3, VtCol, 2'd0, 64'h1111_2222_3333_4444,
                   2'd2, VtCol, 2'd0, 64'h0000_0000_0000_0000};
        for (int k = 0; k < 6; k++) begin
            reset_dut();
            do_write(int'(tab[k].wm), tab[k].wt, int'(tab[k].wi), tab[k].wd);
            do_read(int'(tab[k].rm), tab[k].rt, int'(tab[k].ri), v);
            check($sformatf("addr_vec%0d", k), v, tab[k].exp);
        end

        // Identity multiply.
        reset_dut();
        for (int r = 0; r < 4; r++) do_write(0, VtRow, r, 64'h1000 << (r * 16));
        do_write(1, VtCol, 0, 64'h0800_E000_2000_1000);
        run_cmd(0, 1, 0, 2, 3);
        do_read(2, VtCol, 3, v);
        check("identity", v, 64'h0800_E000_2000_1000);

        // Random data with aliased mul/src/dst.
        for (int r = 0; r < 4; r++) do_write(1, VtRow, r, {$urandom(), $urandom()});
        run_cmd(1, 1, 0, 1, 0);
        run_cmd(1, 1, 2, 1, 2);
        run_cmd(0, 1, 1, 0, 1);

        // Overflow.
        reset_dut();
        do_write(0, VtRow, 0, 64'h7FFF_7FFF_7FFF_7FFF);
        do_write(1, VtCol, 0, 64'h7FFF_7FFF_7FFF_7FFF);
        run_cmd(0, 1, 0, 2, 0);
        do_read(2, VtCol, 0, v);
`ifdef MAT_VEC_ENGINE_SATURATE_EN
        check("overflow", 64'(v[15:0]), 64'h7FFF);
`else
        check("overflow", 64'(v[15:0]), 64'hFFC0);
`endif

        // Negative rounding.
        reset_dut();
        do_write(0, VtRow, 0, 64'h0000_0000_0000_F000);
        do_write(1, VtCol, 0, 64'h0000_0000_0000_0001);
        run_cmd(0, 1, 0, 2, 0);
        do_read(2, VtCol, 0, v);
        check("neg_round", 64'(v[15:0]), 64'hFFFF);

        // Data write and command attempt while busy.
        @(negedge clk);
        start_cmd(0, 1, 0, 2, 1);
        wait_accept();
        @(negedge clk);
        dat_cyc = 1'b1; dat_we = 1'b1; dat_mat_idx = 2'd3; dat_vector_type = VtCol;
        dat_vector_idx = 2'd0; dat_in = 64'hDEAD_BEEF_CAFE_F00D; cmd_valid = 1'b1;
        #1 check("busy_ack", 64'(dat_ack), 64'd0);
        check("busy_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        dat_cyc = 1'b0; dat_we = 1'b0; cmd_valid = 1'b0;
        #1 wait_done(3);
        do_read(3, VtCol, 0, v);
        check("busy_nowrite", v, 64'd0);

        // Data port wins over a simultaneous command.
        @(negedge clk);
        dat_cyc = 1'b1; dat_we = 1'b0;
        start_cmd(0, 1, 0, 3, 2);
        #1 check("both_ack", 64'(dat_ack), 64'd1);
        check("both_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        dat_cyc = 1'b0;
        wait_accept();
        wait_done(1);

        // Reset in the middle of a command.
        do_write(1, VtCol, 3, 64'h1000_1000_1000_1000);
        @(negedge clk);
        start_cmd(0, 1, 3, 2, 2);
        wait_accept();
        @(negedge clk);
        rst_n = 1'b0; dat_cyc = 1'b1; cmd_valid = 1'b1;
        #1 check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_ack", 64'(dat_ack), 64'd0);
        check("midrst_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        dat_cyc = 1'b0; cmd_valid = 1'b0; rst_n = 1'b1;
        clear_model();
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1 if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                do_read(m, VtCol, c, v);
                check($sformatf("midrst_m%0d_c%0d", m, c), v, 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
